// File: rtl/uint16_stack_ctrl.sv
// uint16_stack_ctrl: LIFO push/pop controller in front of a 32-word UInt16 RAM,
// owning the stack pointer and returning one registered response per command.
module uint16_stack_ctrl #(
    parameter int DEPTH = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_op_i,
    input  logic [15:0] cmd_data_i,
    input  logic        clear_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [15:0] rsp_data_o,
    output logic        rsp_error_o,
    output logic [5:0]  count_o,
    output logic        full_o,
    output logic        empty_o,
    output logic [15:0] ram_address_o,
    output logic        ram_read_o,
    output logic        ram_write_o,
    output logic [15:0] ram_input_data_o,
    input  logic [15:0] ram_output_data_i
);
    localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3;

    logic [1:0]  state_q, state_d;
    logic        op_q, op_d;
    logic [5:0]  count_q, count_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [15:0] rsp_data_q, rsp_data_d;
    logic        rsp_error_q, rsp_error_d;
    logic        ram_read_q, ram_read_d;
    logic        ram_write_q, ram_write_d;
    logic [4:0]  addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        accept, reject;

    assign cmd_ready_o      = (state_q == IDLE) && !clear_i;
    assign full_o           = count_q == 6'(DEPTH);
    assign empty_o          = count_q == 6'd0;
    assign count_o          = count_q;
    assign rsp_valid_o      = rsp_valid_q;
    assign rsp_data_o       = rsp_data_q;
    assign rsp_error_o      = rsp_error_q;
    assign ram_read_o       = ram_read_q;
    assign ram_write_o      = ram_write_q;
    assign ram_address_o    = {11'd0, addr_q};
    assign ram_input_data_o = wdata_q;
    assign accept           = cmd_valid_i && cmd_ready_o;
    assign reject           = cmd_op_i ? empty_o : full_o;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        count_d     = count_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_error_d = rsp_error_q;
        ram_read_d  = 1'b0;
        ram_write_d = 1'b0;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        case (state_q)
            IDLE: begin
                if (clear_i) begin
                    count_d = '0;
                end else if (accept && reject) begin
                    rsp_valid_d = 1'b1;
                    rsp_error_d = 1'b1;
                    rsp_data_d  = '0;
                    state_d     = RESP;
                end else if (accept) begin
                    // count is committed now; the RAM access follows in ISSUE
                    op_d        = cmd_op_i;
                    state_d     = ISSUE;
                    ram_read_d  = cmd_op_i;
                    ram_write_d = !cmd_op_i;
                    addr_d      = cmd_op_i ? count_q[4:0] - 5'd1 : count_q[4:0];
                    wdata_d     = cmd_op_i ? wdata_q : cmd_data_i;
                    count_d     = cmd_op_i ? count_q - 6'd1 : count_q + 6'd1;
                end
            end
            ISSUE: begin
                state_d     = op_q ? WAIT : RESP;
                rsp_valid_d = !op_q;
                rsp_error_d = 1'b0;
                rsp_data_d  = '0;
            end
            WAIT: begin
                rsp_valid_d = 1'b1;
                rsp_error_d = 1'b0;
                rsp_data_d  = ram_output_data_i;
                state_d     = RESP;
            end
            default: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_q        <= 1'b0;
            count_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_error_q <= 1'b0;
            ram_read_q  <= 1'b0;
            ram_write_q <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            count_q     <= count_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_error_q <= rsp_error_d;
            ram_read_q  <= ram_read_d;
            ram_write_q <= ram_write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
        end
    end
endmodule
